// File: rtl/left_shifter_pipe.sv
// Pipelined 64-bit logical left shifter: three shift stages (2 shamt bits each) plus an output register.
// Optional carry-out flag enabled by defining SHL_CARRY_EN; otherwise out_cf is tied to 0.
module left_shifter_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [5:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_zf,
    output logic        out_cf
);
    // Handshake: a beat moves when valid && ready at a rising edge. The whole pipe
    // advances together whenever the output slot is empty or being drained.
    logic        w_en;

    logic [63:0] r_d1;
    logic [3:0]  r_s1;
    logic        r_v1;
    logic [63:0] r_d2;
    logic [1:0]  r_s2;
    logic        r_v2;
    logic [63:0] r_d3;
    logic        r_v3;
    logic [63:0] r_out_data;
    logic        r_out_zf;
    logic        r_out_valid;

    logic [63:0] w_s1;
    logic [63:0] w_s2;
    logic [63:0] w_s3;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    assign w_s1 = in_data << in_shamt[1:0];
    assign w_s2 = r_d1 << {r_s1[1:0], 2'b00};
    assign w_s3 = r_d2 << {r_s2, 4'b0000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1        <= '0;
            r_s1        <= '0;
            r_v1        <= 1'b0;
            r_d2        <= '0;
            r_s2        <= '0;
            r_v2        <= 1'b0;
            r_d3        <= '0;
            r_v3        <= 1'b0;
            r_out_data  <= '0;
            r_out_zf    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_d1        <= w_s1;
            r_s1        <= in_shamt[5:2];
            r_v1        <= in_valid;
            r_d2        <= w_s2;
            r_s2        <= r_s1[3:2];
            r_v2        <= r_v1;
            r_d3        <= w_s3;
            r_v3        <= r_v2;
            r_out_data  <= r_d3;
            r_out_zf    <= (r_d3 == 64'd0);
            r_out_valid <= r_v3;
        end
    end

    assign out_data  = r_out_data;
    assign out_zf    = r_out_zf;
    assign out_valid = r_out_valid;

`ifdef SHL_CARRY_EN
    // The last bit shifted out is in_data[64 - shamt]; 6-bit wrap gives that index for shamt 1..63.
    logic [5:0] w_cf_idx;
    logic       w_cf_in;
    logic       r_c1;
    logic       r_c2;
    logic       r_c3;
    logic       r_out_cf;

    assign w_cf_idx = 6'd0 - in_shamt;
    assign w_cf_in  = (in_shamt != 6'd0) && in_data[w_cf_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c1     <= 1'b0;
            r_c2     <= 1'b0;
            r_c3     <= 1'b0;
            r_out_cf <= 1'b0;
        end else if (w_en) begin
            r_c1     <= w_cf_in;
            r_c2     <= r_c1;
            r_c3     <= r_c2;
            r_out_cf <= r_c3;
        end
    end

    assign out_cf = r_out_cf;
`else
    assign out_cf = 1'b0;
`endif

endmodule

// File: tb/tb_left_shifter_pipe.sv
// Scoreboard bench for left_shifter_pipe: driver pushes expected results, a negedge monitor pops and compares.
module tb_left_shifter_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [5:0]  in_shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_zf;
    logic        out_cf;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q[$];  // {cf, zf, data}
    int   rdy_mode = 0;     // 0: out_ready = rdy_force, 1: random
    logic rdy_force = 1'b1;

    left_shifter_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zf(out_zf), .out_cf(out_cf)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] model(input logic [63:0] d, input logic [5:0] s);
        logic [63:0] r;
        logic        cf;
        int          idx;
        r   = d << s;
        cf  = 1'b0;
        idx = 64 - int'(s);
`ifdef SHL_CARRY_EN
        if (s != 6'd0) cf = d[idx];
`endif
        return {cf, (r == 64'd0), r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge with in_valid still high.
    task automatic send(input logic [63:0] d, input logic [5:0] s);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !rst) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=%0b expected 1", in_ready);
        end else begin
            exp_q.push_back(model(d, s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Monitor: every output handshake pops the oldest expected result.
    initial begin
        logic [63:0] held;
        logic        held_v;
        logic [65:0] e;
        held   = '0;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    if (held_v) chk("stall_hold", out_data, held);
                    held   = out_data;
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", out_data, e[63:0]);
                        chk("zf", 64'(out_zf), 64'(e[64]));
                        chk("cf", 64'(out_cf), 64'(e[65]));
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_zf", 64'(out_zf), 64'd0);
        chk("rst_out_cf", 64'(out_cf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        rdy_force = 1'b1;
        idle(2);

        // Latency of a single operand.
        send(64'h0000_0000_0000_0001, 6'd63);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'd3);
        idle(3);

        // Directed corner vectors.
        send(64'hFFFF_FFFF_FFFF_FFFF, 6'd4);
        send(64'h8000_0000_0000_0000, 6'd1);
        send(64'h1234_5678_9ABC_DEF0, 6'd0);
        send(64'h0000_0000_0000_0000, 6'd5);
        send(64'h8000_0000_0000_0001, 6'd63);
        send(64'h0000_0000_FFFF_0000, 6'd32);
        idle(8);

        // Back-to-back with a mid-stream stall.
        fork
            begin
                for (int k = 0; k < 8; k++) send(64'h1, 6'(k));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                rdy_force = 1'b0;
                repeat (5) @(posedge clk);
                rdy_force = 1'b1;
            end
        join
        idle(15);
        chk("drain_b2b", 64'(exp_q.size()), 64'd0);

        // Random operands under random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            send({$urandom(), $urandom()}, 6'($urandom_range(0, 63)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        rdy_force = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_rand", 64'(exp_q.size()), 64'd0);

        // Reset with operands in flight.
        rdy_force = 1'b0;
        idle(2);
        send(64'hAAAA_AAAA_AAAA_AAAA, 6'd1);
        send(64'h5555_5555_5555_5555, 6'd2);
        send(64'h0F0F_0F0F_0F0F_0F0F, 6'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        rdy_force = 1'b1;
        idle(10);
        chk("midrst_no_output", 64'(exp_q.size()), 64'd0);
        chk("midrst_idle_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
